serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_serial_add_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshakes on both sides.
// One full-adder stage consumes one operand bit per cycle, LSB first.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_nxt;

    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // Sum bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_nxt = sum_bit;
        end else begin : g_res_wide
            assign res_nxt = {sum_bit, res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        res      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_nxt;
                    res   <= res_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready returns only after the edge that retires the result.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign s    = out_valid ? res : '0;
    assign cout = out_valid & carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [7:0] a, b, s;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [0:0] a1, b1, s1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .s(s1), .cout(cout1), .busy(busy1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers one operand set, scrambles inputs while running, waits for the result.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                                 input logic [7:0] es, input logic ec, input string tag);
        int lat;
        int busyCnt;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc;
        checkOutput({tag, "_busy_run"}, 64'(busy), 64'd1);
        checkOutput({tag, "_inready_run"}, 64'(in_ready), 64'd0);
        lat = 0;
        busyCnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busyCnt++;
            if (s !== 8'h00) checkOutput({tag, "_s_zero_run"}, 64'(s), 64'd0);
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd8);
        checkOutput({tag, "_busy_cycles"}, 64'(busyCnt), 64'd8);
        checkOutput({tag, "_s"}, 64'(s), 64'(es));
        checkOutput({tag, "_cout"}, 64'(cout), 64'(ec));
        checkOutput({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        tick();
        checkOutput({tag, "_ov_idle"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_inready_idle"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_s_idle"}, 64'(s), 64'd0);
        checkOutput({tag, "_cout_idle"}, 64'(cout), 64'd0);
    endtask

    initial begin
        logic [7:0] hs;
        logic       hc;
        logic [8:0] ref_sum;
        logic [8:0] pend;
        logic       hs_in, hs_out, prev_ov;
        int         cyc, acc_cyc, done_ops;

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_inready", 64'(in_ready), 64'd1);
        checkOutput("rst_outvalid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_s", 64'(s), 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);

        rst_n = 1'b1;
        applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add5a3c");
        retire("add5a3c");
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "addff01");
        retire("addff01");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "addffff1");
        retire("addffff1");

        // Backpressure: result must hold while in_valid pulses are ignored.
        out_ready = 1'b0;
        applyStimulus(8'h81, 8'h7E, 1'b1, 8'h00, 1'b1, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'h11 * 8'(i); b = 8'h22; cin = 1'b1;
            tick();
            checkOutput("bp_hold_ov", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_s", 64'(s), 64'h00);
            checkOutput("bp_hold_cout", 64'(cout), 64'd1);
            checkOutput("bp_hold_inready", 64'(in_ready), 64'd0);
            checkOutput("bp_hold_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;
        retire("bp");

        // Reset mid-RUN discards the operation at once.
        a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        checkOutput("midrst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_inready", 64'(in_ready), 64'd1);
        checkOutput("midrst_outvalid", 64'(out_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_s", 64'(s), 64'd0);
        checkOutput("midrst_cout", 64'(cout), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("midrst_no_stale", 64'(out_valid), 64'd0);
            tick();
        end
        applyStimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "postrst");
        retire("postrst");

        // WIDTH=1 instance: RUN lasts a single cycle.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        checkOutput("w1_busy", 64'(busy1), 64'd1);
        checkOutput("w1_ov_early", 64'(out_valid1), 64'd0);
        tick();
        checkOutput("w1_ov", 64'(out_valid1), 64'd1);
        checkOutput("w1_s", 64'(s1), 64'd1);
        checkOutput("w1_cout", 64'(cout1), 64'd1);
        tick();
        checkOutput("w1_inready", 64'(in_ready1), 64'd1);

        // Back-to-back random traffic with in_valid held high.
        in_valid = 1'b1;
        cyc = 0; acc_cyc = 0; done_ops = 0; prev_ov = 1'b0; pend = '0;
        while (done_ops < 1000 && cyc < 40000) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            out_ready = 1'($urandom);
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_in) pend = {1'b0, a} + {1'b0, b} + 9'(cin);
            if (hs_out) begin
                ref_sum = pend;
                checkOutput("rand_s", 64'(s), 64'(ref_sum[7:0]));
                checkOutput("rand_cout", 64'(cout), 64'(ref_sum[8]));
                done_ops++;
            end
            tick();
            cyc++;
            if (hs_in) acc_cyc = cyc;
            if (out_valid && !prev_ov) checkOutput("rand_latency", 64'(cyc - acc_cyc), 64'd8);
            prev_ov = out_valid;
        end
        checkOutput("rand_ops_done", 64'(done_ops), 64'd1000);
        in_valid = 1'b0;

        hs = 8'h00; hc = 1'b0;
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
